ball_engine: RTL and testbench

Pong ball physics stage, directly downstream of the left/right paddle blocks. Consumes both paddles' y positions and their smash requests. Advances the ball once per game tick and resolves wall bounces, paddle hits and misses. Keeps score and drives ball coordinates plus event pulses to the renderer and score display.

---
 rtl/ball_engine_pkg.sv | 44 ++++
 rtl/ball_engine_step_divider.sv | 34 +++
 rtl/ball_engine.sv | 209 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ball_engine_pkg.sv
// rtl/ball_engine_pkg.sv - shared Pong geometry, state encoding and overlap helper
//
// Purpose: playfield and paddle geometry shared by the ball engine and the
// paddle blocks, the game state encoding, and the vertical overlap test
// between the ball and a paddle.
// Ports: none (package).
package ball_engine_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_H   = 64;
  localparam int PADDLE_W   = 8;
  localparam int PADDLE_L_X = 16;
  localparam int PADDLE_R_X = 616;

  localparam logic [9:0] BALL_X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0 = 10'((SCREEN_H - BALL_SIZE) / 2);

  // Signed 11-bit limits used by the step arithmetic.
  localparam logic signed [10:0] FACE_L_S = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] HIT_R_S  = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [10:0] X_MAX_S  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX_S  = 11'(SCREEN_H - BALL_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  // 11-bit unsigned so an out-of-range paddle y (up to 1023) plus PADDLE_H
  // does not wrap.
  function automatic logic ball_overlap(input logic [9:0] by, input logic [9:0] py);
    logic [10:0] b;
    logic [10:0] p;
    b = {1'b0, by};
    p = {1'b0, py};
    return ((b + 11'(BALL_SIZE)) > p) && (b < (p + 11'(PADDLE_H)));
  endfunction

endpackage

// File: rtl/ball_engine_step_divider.sv
// rtl/ball_engine_step_divider.sv - free-running game step pulse generator
//
// Purpose: counts clk cycles 0..TICK_DIV-1 and raises step_o for the one
// cycle in which the counter wraps.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   step_o out one-clk step pulse every TICK_DIV cycles
module ball_engine_step_divider #(
  parameter int TICK_DIV = 416667
) (
  input  logic clk,
  input  logic reset,
  output logic step_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign step_o = (cnt_q == LAST);

endmodule

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball physics, scoring and match state
//
// Purpose: advances the ball once per game step, resolves wall bounces,
// paddle hits and misses, keeps score and flags the end of the match.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  level; begins a match from IDLE/OVER
//   paddle_l_y, paddle_r_y paddle top edges (sampled on step cycles)
//   smash_l, smash_r       smash held: a hit returns the ball at speed 2
//   ball_x, ball_y         ball top-left corner
//   score_l, score_r       scores, saturating at WIN_SCORE
//   hit, point_l, point_r  one-clk event pulses
//   game_over              high in OVER
module ball_engine
  import ball_engine_pkg::*;
#(
  parameter int TICK_DIV    = 416667,
  parameter int SERVE_STEPS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  input  logic       smash_l,
  input  logic       smash_r,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over
);

  localparam int SW = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_STEPS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_t        state_q;
  logic [9:0]    ball_x_q, ball_y_q, ball_x_d, ball_y_d;
  logic          dx_neg_q, dy_neg_q, fast_q, dx_neg_d, dy_neg_d, fast_d;
  logic [SW-1:0] serve_cnt_q;
  logic [3:0]    score_l_q, score_r_q, score_l_inc, score_r_inc;
  logic          hit_q, point_l_q, point_r_q, game_over_q;
  logic          scorer_l_q;
  logic          hit_d, goal_l_d, goal_r_d;
  logic          step;
  logic signed [10:0] vel, nx, ny;

  ball_engine_step_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .step_o (step)
  );

  assign score_l_inc = (score_l_q >= WIN) ? score_l_q : score_l_q + 4'd1;
  assign score_r_inc = (score_r_q >= WIN) ? score_r_q : score_r_q + 4'd1;

  // One PLAY step: vertical and horizontal resolution are independent, so a
  // corner can flip both directions in the same step.
  always_comb begin
    vel = fast_q ? 11'sd2 : 11'sd1;
    if (dx_neg_q) vel = -vel;
    nx = $signed({1'b0, ball_x_q}) + vel;
    ny = $signed({1'b0, ball_y_q}) + (dy_neg_q ? -11'sd1 : 11'sd1);

    ball_y_d = ny[9:0];
    dy_neg_d = dy_neg_q;
    if (ny <= 11'sd0) begin
      ball_y_d = '0;
      dy_neg_d = 1'b0;
    end else if (ny >= Y_MAX_S) begin
      ball_y_d = Y_MAX_S[9:0];
      dy_neg_d = 1'b1;
    end

    ball_x_d = nx[9:0];
    dx_neg_d = dx_neg_q;
    fast_d   = fast_q;
    hit_d    = 1'b0;
    goal_l_d = 1'b0;
    goal_r_d = 1'b0;
    // Overlap uses the pre-step ball_y, not the bounced one.
    if (dx_neg_q && (nx <= FACE_L_S) && ball_overlap(ball_y_q, paddle_l_y)) begin
      ball_x_d = FACE_L_S[9:0];
      dx_neg_d = 1'b0;
      fast_d   = smash_l;
      hit_d    = 1'b1;
    end else if (!dx_neg_q && (nx >= HIT_R_S) && ball_overlap(ball_y_q, paddle_r_y)) begin
      ball_x_d = HIT_R_S[9:0];
      dx_neg_d = 1'b1;
      fast_d   = smash_r;
      hit_d    = 1'b1;
    end else if (nx <= 11'sd0) begin
      ball_x_d = '0;
      goal_r_d = 1'b1;
    end else if (nx >= X_MAX_S) begin
      ball_x_d = X_MAX_S[9:0];
      goal_l_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      fast_q      <= 1'b0;
      serve_cnt_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      scorer_l_q  <= 1'b0;
      hit_q       <= 1'b0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          ball_x_q <= BALL_X0;
          ball_y_q <= BALL_Y0;
          if (start) begin
            score_l_q   <= '0;
            score_r_q   <= '0;
            dx_neg_q    <= 1'b0;
            fast_q      <= 1'b0;
            serve_cnt_q <= '0;
            game_over_q <= 1'b0;
            state_q     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          ball_x_q <= BALL_X0;
          ball_y_q <= BALL_Y0;
          fast_q   <= 1'b0;
          if (step) begin
            if (serve_cnt_q == SERVE_LAST) begin
              serve_cnt_q <= '0;
              state_q     <= ST_PLAY;
            end else begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (step) begin
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            fast_q   <= fast_d;
            hit_q    <= hit_d;
            if (goal_l_d || goal_r_d) begin
              scorer_l_q <= goal_l_d;
              state_q    <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          // Ball recentres here; the next serve heads toward the conceding side.
          ball_x_q    <= BALL_X0;
          ball_y_q    <= BALL_Y0;
          fast_q      <= 1'b0;
          serve_cnt_q <= '0;
          if (scorer_l_q) begin
            point_l_q <= 1'b1;
            score_l_q <= score_l_inc;
            dx_neg_q  <= 1'b0;
            if (score_l_inc == WIN) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= ST_SERVE;
            end
          end else begin
            point_r_q <= 1'b1;
            score_r_q <= score_r_inc;
            dx_neg_q  <= 1'b1;
            if (score_r_inc == WIN) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign hit       = hit_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - scoreboard bench for ball_engine
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] paddle_l_y = 10'd0;
  logic [9:0] paddle_r_y = 10'd0;
  logic       smash_l = 1'b0;
  logic       smash_r = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       hit, point_l, point_r, game_over;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int kind;  // 0 hit, 1 point_l, 2 point_r
    int x;
    int y;
    int sl;
    int sr;
  } ev_t;

  ev_t exp_q[$];

  ball_engine #(.TICK_DIV(2), .SERVE_STEPS(2), .WIN_SCORE(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .smash_l    (smash_l),
    .smash_r    (smash_r),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .hit        (hit),
    .point_l    (point_l),
    .point_r    (point_r),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int x, input int y, input int sl, input int sr);
    ev_t e;
    e.kind = kind; e.x = x; e.y = y; e.sl = sl; e.sr = sr;
    exp_q.push_back(e);
  endtask

  // Monitor: every event pulse pops the next expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (!reset && (hit || point_l || point_r)) begin
      kind = hit ? 0 : (point_l ? 1 : 2);
      check("ev_onehot", int'(hit) + int'(point_l) + int'(point_r), 1);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got kind %0d at (%0d,%0d) expected none", kind, ball_x, ball_y);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_x", int'(ball_x), e.x);
        check("ev_y", int'(ball_y), e.y);
        check("ev_score_l", int'(score_l), e.sl);
        check("ev_score_r", int'(score_r), e.sr);
      end
    end
  end

  task automatic wait_kind(input int kind, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((kind == 0 && hit) || (kind == 1 && point_l) || (kind == 2 && point_r)) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL event_timeout: got no kind %0d event expected one within %0d clks", kind, budget);
  endtask

  task automatic wait_move(input int budget, output int x_o, output int y_o, output int cyc_o);
    int x0;
    int y0;
    x0 = ball_x;
    y0 = ball_y;
    x_o = x0;
    y_o = y0;
    cyc_o = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc_o = i + 1;
      if (int'(ball_x) != x0 || int'(ball_y) != y0) begin
        x_o = ball_x;
        y_o = ball_y;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL move_timeout: got no motion expected motion within %0d clks", budget);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int x, y, cyc, bad, found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ball_x", int'(ball_x), 316);
    check("rst_ball_y", int'(ball_y), 236);
    reset = 1'b0;
    check("rst_scores", int'(score_l) + int'(score_r), 0);
    check("rst_game_over", int'(game_over), 0);

    // IDLE without start: centred, no events
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ball_x != 10'd316 || ball_y != 10'd236 || hit || point_l || point_r) bad++;
    end
    check("idle_quiet", bad, 0);

    // Scenario A: right hit, smash hit on left, then left scores
    paddle_r_y = 10'd400;
    paddle_l_y = 10'd157;
    smash_l = 1'b1;
    smash_r = 1'b0;
    push_ev(0, 608, 416, 0, 0);
    push_ev(0, 24, 168, 0, 0);
    push_ev(1, 316, 236, 1, 0);
    pulse_start();
    wait_move(20, x, y, cyc);
    check("serve_hold_ok", int'(cyc >= 5 && cyc <= 6), 1);
    check("first_x", x, 317);
    check("first_y", y, 237);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ball_y == 10'd471) found = 1;
    end
    check("reach_y471", found, 1);
    wait_move(10, x, y, cyc);
    check("floor_y", y, 472);
    check("floor_x", x, 552);
    wait_move(10, x, y, cyc);
    check("after_floor_y", y, 471);

    wait_kind(0, 2000);
    wait_kind(0, 2000);
    paddle_r_y = 10'd0;
    wait_move(10, x, y, cyc);
    check("smash_x", x, 26);
    check("smash_y", y, 169);

    wait_kind(1, 2000);
    check("a_score_l", int'(score_l), 1);
    wait_move(20, x, y, cyc);
    check("serve_a_x", x, 317);
    check("serve_a_y", y, 235);

    // Reset mid-PLAY takes effect without a clock edge
    #2 reset = 1'b1;
    #1;
    check("midrst_x", int'(ball_x), 316);
    check("midrst_y", int'(ball_y), 236);
    check("midrst_score_l", int'(score_l), 0);
    check("midrst_game_over", int'(game_over), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Scenario B: right hit, then three left misses end the match
    paddle_r_y = 10'd400;
    paddle_l_y = 10'd300;
    smash_l = 1'b0;
    smash_r = 1'b0;
    push_ev(0, 608, 416, 0, 0);
    push_ev(2, 316, 236, 0, 1);
    push_ev(2, 316, 236, 0, 2);
    push_ev(2, 316, 236, 0, 3);
    pulse_start();
    wait_kind(0, 2000);
    wait_kind(2, 3000);
    wait_move(20, x, y, cyc);
    check("serve_b_x", x, 315);
    check("serve_b_y", y, 237);
    wait_kind(2, 3000);
    wait_kind(2, 3000);
    check("over_flag", int'(game_over), 1);
    check("over_score_r", int'(score_r), 3);
    repeat (20) @(negedge clk);
    check("over_hold_flag", int'(game_over), 1);
    check("over_hold_score_r", int'(score_r), 3);
    check("over_ball_x", int'(ball_x), 316);

    pulse_start();
    check("restart_score_r", int'(score_r), 0);
    check("restart_game_over", int'(game_over), 0);
    wait_move(20, x, y, cyc);
    check("restart_x", x, 317);
    check("restart_y", y, 237);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
